// File: rtl/register_fifo_r_en_pkg.sv
// Shared definitions for the register_fifo_r_en FIFO.
//
// Contents:
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default word width and entry count
//   clog2_f                       : ceiling log2, used to size the pointers
//
// Optional feature macro: REGISTER_FIFO_CLR_EN. It is deliberately left
// undefined here. Define it on the tool command line to add the synchronous
// clr flush input to the top module.
package register_fifo_r_en_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH = 8;

  // Returns the number of bits needed to index n entries (minimum 1).
  function automatic int unsigned clog2_f(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 1) ? n - 1 : 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/register_fifo_r_en_register_r_en.sv
// register_r_en: WIDTH-bit storage register with asynchronous active-low
// reset and a load enable. One instance holds one FIFO entry.
//
// Ports:
//   clk_i  : rising-edge clock
//   rst_ni : asynchronous active-low reset, clears the word to 0
//   en_i   : load enable; d_i is captured on the clock edge when high
//   d_i    : data to load
//   q_o    : stored word
module register_r_en
  import register_fifo_r_en_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/register_fifo_r_en.sv
// register_fifo_r_en: DEPTH-entry synchronous FIFO built from enabled,
// resettable storage registers (register_r_en).
//
// Parameters:
//   WIDTH : data word width
//   DEPTH : number of entries, power of two, >= 2
//   AW    : pointer width, derived from DEPTH (not overridable)
//
// Ports:
//   clk       : rising-edge clock
//   reset_n   : asynchronous active-low reset
//   wr_en     : push request, d_in captured when accepted
//   d_in      : write data
//   rd_en     : pop request
//   d_out     : registered read data, valid the cycle after an accepted pop
//   full      : count == DEPTH
//   empty     : count == 0
//   count     : occupancy, 0..DEPTH
//   overflow  : one-cycle pulse after a refused push
//   underflow : one-cycle pulse after a refused pop
//   clr       : synchronous flush (only when REGISTER_FIFO_CLR_EN is defined)
//
// Optional feature macro: REGISTER_FIFO_CLR_EN.
module register_fifo_r_en
  import register_fifo_r_en_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             wr_en,
  input  logic [WIDTH-1:0]                 d_in,
  input  logic                             rd_en,
`ifdef REGISTER_FIFO_CLR_EN
  input  logic                             clr,
`endif
  output logic [WIDTH-1:0]                 d_out,
  output logic                             full,
  output logic                             empty,
  output logic [clog2_f(DEPTH):0]          count,
  output logic                             overflow,
  output logic                             underflow
);

  localparam int unsigned AW = clog2_f(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic [WIDTH-1:0] mem [DEPTH];

  logic full_w;
  logic empty_w;
  logic pop_ok;
  logic push_ok;
  logic clr_w;
  logic push_acc;
  logic pop_acc;

`ifdef REGISTER_FIFO_CLR_EN
  assign clr_w = clr;
`else
  assign clr_w = 1'b0;
`endif

  // Status comes from the registered count only, so there is no
  // combinational path from wr_en/rd_en to full/empty/count.
  assign full_w  = (count_q == DEPTH_CNT);
  assign empty_w = (count_q == '0);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a
  // push alongside a pop. An empty FIFO never bypasses a push to the pop.
  assign pop_ok  = rd_en & ~empty_w;
  assign push_ok = wr_en & (~full_w | pop_ok);

  // A flush overrides any transfer in the same cycle.
  assign push_acc = push_ok & ~clr_w;
  assign pop_acc  = pop_ok & ~clr_w;

  // Storage: one enabled register per entry, loaded only when it is the
  // write target of an accepted push.
  for (genvar i = 0; i < DEPTH; i++) begin : g_store
    logic en_w;
    assign en_w = push_acc & (wr_ptr_q == AW'(i));

    register_r_en #(
      .WIDTH (WIDTH)
    ) u_word (
      .clk_i  (clk),
      .rst_ni (reset_n),
      .en_i   (en_w),
      .d_i    (d_in),
      .q_o    (mem[i])
    );
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;

    if (clr_w) begin
      // d_out and storage keep their contents; no error pulses on a flush.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      ovf_d = wr_en & ~push_ok;
      udf_d = rd_en & ~pop_ok;

      if (push_acc) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end

      if (pop_acc) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        dout_d   = mem[rd_ptr_q];
      end

      unique case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign d_out     = dout_q;
  assign full      = full_w;
  assign empty     = empty_w;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_register_fifo_r_en.sv
// Self-checking bench for register_fifo_r_en (WIDTH=8, DEPTH=8).
module tb_register_fifo_r_en;

  localparam int W = 8;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         wr_en;
  logic         rd_en;
  logic [W-1:0] d_in;
  logic [W-1:0] d_out;
  logic         full;
  logic         empty;
  logic [3:0]   count;
  logic         overflow;
  logic         underflow;
`ifdef REGISTER_FIFO_CLR_EN
  logic         clr;
`endif

  always #5 clk = ~clk;

  register_fifo_r_en #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .d_in      (d_in),
    .rd_en     (rd_en),
`ifdef REGISTER_FIFO_CLR_EN
    .clr       (clr),
`endif
    .d_out     (d_out),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge; return 1 ns after the
  // following rising edge so outputs reflect that edge.
  task automatic drive(input bit wr, input bit rd, input logic [W-1:0] din);
    @(negedge clk);
    wr_en = wr;
    rd_en = rd;
    d_in  = din;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] e_dout, input int e_cnt,
                         input bit e_ovf, input bit e_udf);
    chk({tag, " d_out"},     d_out,     e_dout);
    chk({tag, " count"},     count,     e_cnt);
    chk({tag, " full"},      full,      (e_cnt == D));
    chk({tag, " empty"},     empty,     (e_cnt == 0));
    chk({tag, " overflow"},  overflow,  e_ovf);
    chk({tag, " underflow"}, underflow, e_udf);
  endtask

  // Directed vector table.
  typedef struct {
    bit         wr;
    bit         rd;
    logic [7:0] din;
    logic [7:0] dout;
    int         cnt;
    bit         ovf;
    bit         udf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit wr, bit rd, logic [7:0] din, logic [7:0] dout,
                              int cnt, bit ovf, bit udf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = din; v.dout = dout;
    v.cnt = cnt; v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  // Behavioural reference: a queue of words plus the last popped value.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_dout;

  task automatic mstep(input string tag, input bit wr, input bit rd, input logic [W-1:0] din);
    bit pop_ok;
    bit push_ok;
    pop_ok  = rd && (mq.size() > 0);
    push_ok = wr && ((mq.size() < D) || pop_ok);
    if (pop_ok)  m_dout = mq.pop_front();
    if (push_ok) mq.push_back(din);
    drive(wr, rd, din);
    chk_all(tag, m_dout, mq.size(), wr && !push_ok, rd && !pop_ok);
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    d_in    = '0;
`ifdef REGISTER_FIFO_CLR_EN
    clr     = 1'b0;
`endif

    // Reset state while reset is held, then after release with idle inputs.
    #12;
    chk_all("reset", 8'h00, 0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    chk_all("idle", 8'h00, 0, 1'b0, 1'b0);

    // Directed table: fill, overflow, full push+pop, drain, empty corners.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 0, 8'((i + 1) * 17), 8'h00, i + 1, 0, 0));
    vecs.push_back(mk(1, 0, 8'h99, 8'h00, 8, 1, 0));
    vecs.push_back(mk(1, 1, 8'hAA, 8'h11, 8, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 8'h22, 7, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 8'h33, 6, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 8'h44, 5, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 8'h55, 4, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 8'h66, 3, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 8'h77, 2, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 8'h88, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 8'hAA, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 8'hAA, 0, 0, 1));
    vecs.push_back(mk(1, 1, 8'h5A, 8'hAA, 1, 0, 1));
    vecs.push_back(mk(0, 1, 8'h00, 8'h5A, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 8'h5A, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].wr, vecs[i].rd, vecs[i].din);
      chk_all($sformatf("vec%0d", i), vecs[i].dout, vecs[i].cnt, vecs[i].ovf, vecs[i].udf);
    end

    // Asynchronous reset between edges with 5 entries stored.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'h31 + 8'(i));
    chk("five stored count", count, 5);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async rst count", count, 0);
    chk("async rst d_out", d_out, 8'h00);
    chk("async rst empty", empty, 1'b1);
    chk("async rst full",  full,  1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    mq.delete();
    m_dout = '0;

    // First push after reset release must be the first word read back.
    mstep("post rst push", 1'b1, 1'b0, 8'hC3);
    mstep("post rst pop",  1'b0, 1'b1, 8'h00);

    // Wrap-around: 20 pushes with incrementing data, pops interleaved.
    for (int i = 0; i < 20; i++) begin
      mstep($sformatf("wrap%0d", i), 1'b1, (i >= 3), 8'h40 + 8'(i));
      if (count > 4'd8) chk("wrap count bound", count, 8);
    end
    while (mq.size() > 0) mstep("wrap drain", 1'b0, 1'b1, 8'h00);

    // Randomized traffic in phases biased to fill, drain and contend.
    for (int ph = 0; ph < 4; ph++) begin
      int pw;
      int pr;
      pw = (ph == 0) ? 75 : (ph == 1) ? 25 : (ph == 2) ? 50 : 90;
      pr = (ph == 0) ? 25 : (ph == 1) ? 75 : (ph == 2) ? 50 : 90;
      for (int n = 0; n < 100; n++) begin
        mstep($sformatf("rand p%0d n%0d", ph, n),
              ($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr),
              8'($urandom));
      end
    end

`ifdef REGISTER_FIFO_CLR_EN
    // Flush with 3 entries stored and a simultaneous push.
    while (mq.size() > 0) mstep("clr pre drain", 1'b0, 1'b1, 8'h00);
    mstep("clr fill0", 1'b1, 1'b0, 8'hE1);
    mstep("clr fill1", 1'b1, 1'b0, 8'hE2);
    mstep("clr fill2", 1'b1, 1'b0, 8'hE3);
    @(negedge clk);
    clr   = 1'b1;
    wr_en = 1'b1;
    rd_en = 1'b0;
    d_in  = 8'hEE;
    @(posedge clk);
    #1;
    mq.delete();
    chk_all("clr", m_dout, 0, 1'b0, 1'b0);
    @(negedge clk);
    clr = 1'b0;
    mstep("clr after push", 1'b1, 1'b0, 8'h12);
    mstep("clr after pop",  1'b0, 1'b1, 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_fifo_r_en.md
# register_fifo_r_en

Parametrised, resettable first-in/first-out buffer built from per-word resettable, enabled storage registers. It generalises the fixed 8-bit enabled register into a DEPTH-entry queue with write/read pointers, occupancy count, full/empty status and error pulses. It is used between datapath stages whose producer and consumer rates differ, such as an operand queue feeding an ALU.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 8, number of storage entries (power of two, ≥2)
- AW, log2(DEPTH), pointer width (derived, not overridden)

- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- wr_en  input  1  push request; d_in is captured when accepted
- d_in  input  WIDTH  write data
- rd_en  input  1  pop request
- d_out  output  WIDTH  registered read data
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- count  output  AW+1  current occupancy, 0..DEPTH
- overflow  output  1  one-cycle pulse: push refused
- underflow  output  1  one-cycle pulse: pop refused
- clr  input  1  synchronous flush; present only with REGISTER_FIFO_CLR_EN

## Operation
- Reset (reset_n low, asynchronous) sets wr_ptr = rd_ptr = 0, count = 0, d_out = 0, overflow = underflow = 0, empty = 1, full = 0. Storage words reset to 0.
- Push is accepted when wr_en = 1 and the FIFO is not full, or when it is full and a pop is accepted in the same cycle. On acceptance, mem[wr_ptr] <= d_in and wr_ptr increments modulo DEPTH.
- Pop is accepted when rd_en = 1 and the FIFO is not empty. On acceptance, d_out <= mem[rd_ptr] and rd_ptr increments modulo DEPTH. If no pop is accepted, d_out holds its value.
- Count update: +1 for a push only, −1 for a pop only, unchanged when both or neither are accepted.
- Simultaneous push and pop:
  - Full: both are accepted; count stays DEPTH; no overflow.
  - Empty: the push is accepted and the pop is refused (no bypass); underflow pulses; count becomes 1.
- A refused push pulses overflow for one cycle, and storage is unchanged. A refused pop pulses underflow for one cycle, and d_out holds.
- Pointer wrap-around is implicit in the AW-bit pointers. full and empty are derived from count, not from pointer comparison.
- Reset asserted mid-operation discards all contents immediately. The first accepted push after release goes to entry 0.

## Timing
- All state updates on the rising edge of clk, except reset.
- Pop latency is 1: data appears on d_out the cycle after the accepted rd_en.
- Push-to-readable latency is 1: a word pushed in cycle N can be popped in cycle N+1, and appears on d_out in cycle N+2.
- full, empty and count are registered-state derived. They reflect the edge's updates in the following cycle, with no combinational path from wr_en or rd_en.
- overflow and underflow are registered, asserting in the cycle after the offending request.

## Configuration
- REGISTER_FIFO_CLR_EN defined:
  - Adds the clr port.
  - clr = 1 at a clock edge zeros the pointers and count and forces empty, taking priority over any push or pop in the same cycle.
  - d_out and storage hold; no error pulses are generated for that cycle.
- Not defined: no clr port; the only way to flush is reset_n.

## Structure
- The shared package/header holds:
  - Default WIDTH/DEPTH constants.
  - The clog2-style function used to derive AW.
  - The REGISTER_FIFO_CLR_EN default (undefined).
- Sub-module register_r_en: WIDTH-parametrised register with asynchronous active-low reset and enable. It is instantiated DEPTH times as storage, with enable = accepted push AND (wr_ptr == index).
- Pointers, count, flags and the d_out register live in the top module.

## Test plan
- Reset, then idle: d_out = 0, count = 0, empty = 1, full = 0, no pulses.
- WIDTH=8, DEPTH=8: push 0x11..0x88, then pop 8 times → d_out sequence 0x11..0x88, one per cycle after each pop; full asserts after the 8th push; empty asserts after the 8th pop.
- Full FIFO: push 0x99 alone → overflow pulses once, count stays 8. Then push 0xAA with a simultaneous pop → no overflow, count 8, and 0xAA is later read in order.
- Empty FIFO: pop alone → underflow pulses, d_out holds. Push 0x5A with a simultaneous pop → underflow pulses, count = 1, and the next pop returns 0x5A.
- Wrap-around: 20 interleaved push/pop cycles with incrementing data → output order is preserved across pointer wrap, and count never exceeds 8.
- Reset asserted asynchronously between edges with 5 entries stored → count = 0, d_out = 0 immediately. With REGISTER_FIFO_CLR_EN, clr with 3 entries stored and a simultaneous push → count = 0, empty = 1, and the push is discarded.
